// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates the condition, computes the target,
// issues a one-cycle fetch redirect, holds a timed flush window and keeps statistics.
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [12:0]       imm,
    input  logic [2:0]        branch_control,
    output logic              resolve_valid,
    output logic              resolve_taken,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush,
    output logic              misalign_exc,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  taken_count,
    output logic [CNT_W-1:0]  squash_count
);

    localparam logic [2:0] BEQ    = 3'b000;
    localparam logic [2:0] BNE    = 3'b001;
    localparam logic [2:0] BR_NOP = 3'b010;
    localparam logic [2:0] BLT    = 3'b100;
    localparam logic [2:0] BGE    = 3'b101;
    localparam logic [2:0] BLTU   = 3'b110;
    localparam logic [2:0] BGEU   = 3'b111;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    function automatic logic cond_taken(
        input logic [2:0]             ctl,
        input logic signed [XLEN-1:0] a,
        input logic signed [XLEN-1:0] b
    );
        logic t;
        t = 1'b0;
        case (ctl)
            BEQ:     t = (a == b);
            BNE:     t = (a != b);
            BLT:     t = (a < b);
            BGE:     t = (a >= b);
            BLTU:    t = ($unsigned(a) < $unsigned(b));
            BGEU:    t = ($unsigned(a) >= $unsigned(b));
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // BR_NOP and the unassigned code 3'b011 are not real branches.
    function automatic logic is_branch(input logic [2:0] ctl);
        return (ctl != BR_NOP) && (ctl != 3'b011);
    endfunction

    function automatic logic [XLEN-1:0] branch_target(
        input logic [XLEN-1:0] pc,
        input logic [12:0]     off
    );
        logic signed [XLEN-1:0] off_ext;
        off_ext = XLEN'($signed(off));
        return pc + off_ext;
    endfunction

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;
    logic                   accept;
    logic                   taken_c;
    logic [XLEN-1:0]        target_c;
    logic                   redirect_c;
    logic                   misalign_c;

    logic [0:0]             state;
    logic [3:0]             flush_cnt;

    logic                   vld_p0;
    logic                   taken_p0;
    logic                   redirect_vld_p0;
    logic [XLEN-1:0]        redirect_pc_p0;
    logic                   misalign_p0;
    logic                   flush_p0;
    logic [CNT_W-1:0]       branch_cnt_p0;
    logic [CNT_W-1:0]       taken_cnt_p0;
    logic [CNT_W-1:0]       squash_cnt_p0;

    assign in_ready = 1'b1;

    assign rs1_s      = rs1_data;
    assign rs2_s      = rs2_data;
    assign accept     = in_valid && (state == ST_RUN);
    assign taken_c    = cond_taken(branch_control, rs1_s, rs2_s);
    assign target_c   = branch_target(pc_in, imm);
    assign redirect_c = accept && taken_c && (target_c[1:0] == 2'b00);
    assign misalign_c = accept && taken_c && (target_c[1:0] != 2'b00);

    // Stage p0: resolve outputs registered at the accept edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= ST_RUN;
            flush_cnt       <= 4'd0;
            vld_p0          <= 1'b0;
            taken_p0        <= 1'b0;
            redirect_vld_p0 <= 1'b0;
            redirect_pc_p0  <= '0;
            misalign_p0     <= 1'b0;
            flush_p0        <= 1'b0;
            branch_cnt_p0   <= '0;
            taken_cnt_p0    <= '0;
            squash_cnt_p0   <= '0;
        end else begin
            vld_p0          <= accept;
            taken_p0        <= accept && taken_c;
            redirect_vld_p0 <= redirect_c;
            misalign_p0     <= misalign_c;
            if (redirect_c) begin
                redirect_pc_p0 <= target_c;
            end
            if (accept && is_branch(branch_control)) begin
                branch_cnt_p0 <= branch_cnt_p0 + 1'b1;
            end
            if (accept && taken_c) begin
                taken_cnt_p0 <= taken_cnt_p0 + 1'b1;
            end

            case (state)
                ST_RUN: begin
                    if (redirect_c) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_INIT;
                        flush_p0  <= 1'b1;
                    end
                end
                default: begin
                    // Anything arriving while the window is open is wrong-path.
                    if (in_valid) begin
                        squash_cnt_p0 <= squash_cnt_p0 + 1'b1;
                    end
                    if (flush_cnt <= 4'd1) begin
                        state     <= ST_RUN;
                        flush_cnt <= 4'd0;
                        flush_p0  <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign resolve_valid  = vld_p0;
    assign resolve_taken  = taken_p0;
    assign redirect_valid = redirect_vld_p0;
    assign redirect_pc    = redirect_pc_p0;
    assign misalign_exc   = misalign_p0;
    assign flush          = flush_p0;
    assign branch_count   = branch_cnt_p0;
    assign taken_count    = taken_cnt_p0;
    assign squash_count   = squash_cnt_p0;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a behavioural model predicts each
// cycle's outputs; a negedge monitor pops and compares.
module tb_branch_resolve_unit;

    localparam int F = 2;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_in, rs1_data, rs2_data;
    logic [12:0] imm;
    logic [2:0]  branch_control;
    logic        resolve_valid, resolve_taken, redirect_valid, flush, misalign_exc;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, taken_count, squash_count;

    branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(F), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .branch_control(branch_control), .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .misalign_exc(misalign_exc),
        .branch_count(branch_count), .taken_count(taken_count),
        .squash_count(squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rv;
        bit          fl;
        logic [31:0] rpc;
        logic [15:0] bc, tc, sc;
    } stat_t;

    typedef struct {
        bit          taken;
        bit          redir;
        bit          mis;
        logic [31:0] tgt;
    } res_t;

    stat_t st_q[$];
    res_t  rs_q[$];

    int total = 0;
    int fails = 0;
    bit mon_en = 0;

    // Model state
    int          sq_left = 0;
    logic [15:0] m_bc = 0, m_tc = 0, m_sc = 0;
    logic [31:0] m_last_pc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_taken(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (c)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 0;
        endcase
    endfunction

    // Drive one edge's worth of inputs and predict the outputs that follow it.
    task automatic step(input bit rst, input bit v, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [12:0] im, input logic [2:0] c);
        stat_t  s;
        res_t   r;
        longint off;
        logic [31:0] tgt;
        bit     tk;
        reset_n = !rst;
        in_valid = v;
        pc_in = pc;
        rs1_data = a;
        rs2_data = b;
        imm = im;
        branch_control = c;
        s.rv = 0;
        if (rst) begin
            sq_left = 0;
            m_bc = 0; m_tc = 0; m_sc = 0;
            m_last_pc = 0;
        end else if (sq_left > 0) begin
            if (v) m_sc = m_sc + 1;
            sq_left--;
        end else if (v) begin
            s.rv = 1;
            off = im[12] ? longint'(im) - 8192 : longint'(im);
            tgt = 32'(longint'(pc) + off);
            tk = model_taken(c, a, b);
            r.taken = tk;
            r.tgt = tgt;
            r.redir = tk && (tgt % 4 == 0);
            r.mis = tk && (tgt % 4 != 0);
            if (c != 3'd2 && c != 3'd3) m_bc = m_bc + 1;
            if (tk) m_tc = m_tc + 1;
            if (r.redir) begin
                m_last_pc = tgt;
                sq_left = F;
            end
            rs_q.push_back(r);
        end
        s.fl = (sq_left > 0);
        s.rpc = m_last_pc;
        s.bc = m_bc;
        s.tc = m_tc;
        s.sc = m_sc;
        st_q.push_back(s);
        @(posedge clk);
        #1;
        mon_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, 32'h0, 13'h0, 3'd2);
    endtask

    // Monitor
    initial begin
        stat_t s;
        res_t  r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (st_q.size() == 0) begin
                    total++; fails++;
                    $display("FAIL status_queue: empty when cycle output present");
                end else begin
                    s = st_q.pop_front();
                    chk("resolve_valid", resolve_valid, s.rv);
                    chk("flush", flush, s.fl);
                    chk("redirect_pc_hold", redirect_pc, s.rpc);
                    chk("branch_count", branch_count, s.bc);
                    chk("taken_count", taken_count, s.tc);
                    chk("squash_count", squash_count, s.sc);
                end
                chk("in_ready", in_ready, 1);
                if (resolve_valid) begin
                    if (rs_q.size() == 0) begin
                        total++; fails++;
                        $display("FAIL resolve_queue: unexpected resolve, got 1 required 0");
                    end else begin
                        r = rs_q.pop_front();
                        chk("resolve_taken", resolve_taken, r.taken);
                        chk("redirect_valid", redirect_valid, r.redir);
                        chk("misalign_exc", misalign_exc, r.mis);
                        if (r.redir) chk("redirect_pc", redirect_pc, r.tgt);
                    end
                end else begin
                    chk("redirect_idle", redirect_valid, 0);
                    chk("misalign_idle", misalign_exc, 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, pc;
        logic [12:0] im;
        reset_n = 0;
        in_valid = 0;
        pc_in = 0; rs1_data = 0; rs2_data = 0; imm = 0; branch_control = 3'd2;
        step(1, 0, 0, 0, 0, 0, 3'd2);
        step(1, 0, 0, 0, 0, 0, 3'd2);
        idle(1);

        // BEQ taken: redirect to 0x110, two-cycle flush
        step(0, 1, 32'h100, 32'h5, 32'h5, 13'h010, 3'd0);
        idle(3);
        // BLT vs BLTU with -1 vs 1
        step(0, 1, 32'h300, 32'hFFFF_FFFF, 32'h1, 13'h008, 3'd4);
        idle(3);
        step(0, 1, 32'h300, 32'hFFFF_FFFF, 32'h1, 13'h008, 3'd6);
        idle(1);
        // Taken BNE followed by three back-to-back inputs
        step(0, 1, 32'h400, 32'h1, 32'h2, 13'h020, 3'd1);
        step(0, 1, 32'h404, 32'h1, 32'h2, 13'h008, 3'd0);
        step(0, 1, 32'h408, 32'h1, 32'h2, 13'h008, 3'd0);
        step(0, 1, 32'h40C, 32'h1, 32'h2, 13'h008, 3'd0);
        idle(2);
        // Negative offset wrapping below zero
        step(0, 1, 32'h4, 32'h7, 32'h7, 13'h1FF0, 3'd0);
        idle(3);
        // Misaligned taken BGE
        step(0, 1, 32'h200, 32'h3, 32'h1, 13'h002, 3'd5);
        idle(2);
        // Reset inside the flush window with an input pending
        step(0, 1, 32'h500, 32'h9, 32'h9, 13'h040, 3'd0);
        step(1, 1, 32'h600, 32'h9, 32'h9, 13'h040, 3'd0);
        idle(2);
        // BR_NOP and undefined code never count as branches
        for (int i = 0; i < 4; i++)
            step(0, 1, 32'h700 + 32'(i * 4), 32'h1, 32'h1, 13'h010, (i % 2 == 0) ? 3'd2 : 3'd3);
        idle(1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom() : a + 32'($urandom_range(0, 2)) - 1);
            pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            pc = pc & 32'hFFFF_FFFC;
            im = 13'($urandom()) & 13'h1FFE;
            step(($urandom_range(0, 80) == 0), ($urandom_range(0, 3) != 0), pc, a, b, im, 3'($urandom()));
        end
        idle(3);
        @(negedge clk);
        #1;
        chk("status_queue_drained", 64'(st_q.size()), 0);
        chk("resolve_queue_drained", 64'(rs_q.size()), 0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
